// File: rtl/appro_div_pkg.sv
// Shared types and sizing helpers for the appro_div sequential restoring divider.
package appro_div_pkg;

  localparam int N_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (2 * n > 2) ? $clog2(2 * n) : 1;
  endfunction

endpackage

// File: rtl/appro_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module appro_div_step #(
  parameter int N = 3
) (
  input  logic [N:0]   r_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_out,
  output logic         q_bit
);

  logic [N:0] r_sh;
  logic [N:0] dvs_ext;

  assign r_sh    = {r_in[N-1:0], bit_in};
  assign dvs_ext = {1'b0, divisor};
  // r_in[N] set means the shifted value already exceeds any N-bit divisor
  assign q_bit   = r_in[N] | (r_sh >= dvs_ext);
  assign r_out   = q_bit ? (r_sh - dvs_ext) : r_sh;

endmodule

// File: rtl/appro_div.sv
// Sequential unsigned restoring divider (2N-bit dividend / N-bit divisor), one quotient bit per cycle.
// Optional DIV_ZERO_DETECT_EN: zero divisor bypasses iteration and flags div_zero.
module appro_div
  import appro_div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero
);

  localparam int             CW   = cnt_width(N);
  localparam logic [CW-1:0]  LAST = CW'(2 * N - 1);

  state_e           state_q, state_d;
  logic [2*N-1:0]   dq_q, dq_d;
  logic [N:0]       r_q, r_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q;
  logic [N:0]       step_r;
  logic             step_q;
`ifdef DIV_ZERO_DETECT_EN
  logic             dz_q, dz_d;
`endif

  // dq_q holds the remaining dividend bits at the top and collects quotient bits at the bottom
  appro_div_step #(.N(N)) u_step (
    .r_in    (r_q),
    .bit_in  (dq_q[2*N-1]),
    .divisor (dvs_q),
    .r_out   (step_r),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
`ifdef DIV_ZERO_DETECT_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          dq_d    = dividend;
          dvs_d   = divisor;
          r_d     = '0;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef DIV_ZERO_DETECT_EN
          dz_d    = 1'b0;
          if (divisor == '0) begin
            dq_d    = '1;
            r_d     = {1'b0, dividend[N-1:0]};
            dz_d    = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        r_d   = step_r;
        dq_d  = {dq_q[2*N-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dq_q    <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign in_ready  = rdy_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = out_valid ? dq_q : '0;
  assign remainder = out_valid ? r_q[N-1:0] : '0;
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero  = out_valid && dz_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: doc/appro_div.md
# appro_div

Sequential unsigned restoring divider, the inverse companion of the approximate 3x3 multiplier in the APIR-DSP datapath. It takes a 2N-bit product-domain dividend and an N-bit divisor, and returns a 2N-bit quotient and an N-bit remainder one bit per cycle. It is used to recover operands and to characterise multiplier error on-chip. Input and output are separate valid/ready handshakes, so the block sits between the DSP result bus and the error-analysis logic.

## Interface
- N, default 3, divisor width; dividend and quotient are 2N bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  block can accept an operation.
- dividend  input  2N  unsigned dividend.
- divisor  input  N  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  2N  floor(dividend/divisor).
- remainder  output  N  dividend mod divisor.
- div_zero  output  1  divisor was zero; valid with out_valid.

## Operation
- FSM states: IDLE, BUSY, DONE, encoded in 2 bits.
- IDLE: in_ready=1.
  - in_valid=1 latches the dividend into a shift register and the divisor into a register.
  - It clears the (N+1)-bit partial remainder and the iteration counter, then goes to BUSY.
- BUSY: each cycle performs one step.
  - r' = {r[N-1:0], dividend MSB}.
  - If r' >= {1'b0, divisor}: r = r' - divisor and shift in quotient bit 1. Otherwise r = r' and shift in 0.
  - The dividend register shifts left by one.
  - The counter counts 0..2N-1; after step 2N-1 the FSM goes to DONE.
- DONE: out_valid=1.
  - quotient, remainder = r[N-1:0], and div_zero are held stable until out_ready=1.
  - Then the FSM goes to IDLE.
- No accept in DONE: in_ready is 0 in BUSY and DONE, and in_valid is ignored there.
- Divisor = 0 without the macro: the algorithm naturally produces quotient = all ones and remainder = dividend[N-1:0].
- Arithmetic is unsigned throughout. The subtraction is N+1 bits wide and cannot overflow because r' < 2*divisor.

## Timing
- Reset (asynchronous, any state, including mid-BUSY):
  - State goes to IDLE; all registers clear.
  - out_valid=0, quotient=0, remainder=0, div_zero=0.
  - in_ready=0 while rst=1 and 1 from the first clock edge after release.
  - An in-flight operation is discarded.
- Latency: accept edge, then 2N BUSY cycles; out_valid rises on the edge ending the last step. With N=3 this is 7 cycles from accept to out_valid.
- Throughput: one operation per 2N+2 cycles when out_ready is tied 1.
- The handshake completes on any edge where valid and ready are both 1. Outputs do not change while out_valid=1 and out_ready=0.
- out_ready is ignored when out_valid=0.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - At accept, divisor==0 skips BUSY and goes directly to DONE on the next edge (1-cycle latency).
  - Outputs: quotient = all ones, remainder = dividend[N-1:0], div_zero=1.
- DIV_ZERO_DETECT_EN undefined:
  - div_zero is tied to 0 and there is no zero compare.
  - Divisor 0 runs the full 2N iterations and produces the same quotient and remainder values.

## Structure
- Package appro_div_pkg:
  - State enum (IDLE, BUSY, DONE).
  - Default N.
  - Counter-width function clog2(2N).
- Sub-module appro_div_step: purely combinational single restoring step.
  - Inputs: r, next bit, divisor.
  - Outputs: new r, quotient bit.
- The top level holds the FSM, counter, shift registers and handshake logic.

## Test plan
- N=3: dividend 42, divisor 6, out_ready=1 -> quotient 7, remainder 0, div_zero 0; out_valid exactly 7 cycles after accept.
- dividend 63, divisor 1 -> quotient 63, remainder 0. Then dividend 5, divisor 7 -> quotient 0, remainder 5.
- dividend 45, divisor 0:
  - With the macro: quotient 63, remainder 5, div_zero 1, out_valid 1 cycle after accept.
  - Without the macro: same quotient and remainder, div_zero 0, 7-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready 0, new in_valid ignored. Release -> one transfer, in_ready=1 the next cycle.
- Reset asserted at BUSY step 3 -> all outputs 0 immediately. After release, 49/7 completes with quotient 7, remainder 0.
- Exhaustive random sweep: all 64x8 dividend/divisor pairs with random out_ready stalls -> matches the reference model, and no dropped or duplicated results.
